// File: rtl/safe_pkg.sv
// Shared constants for the safe lock controller: keypad codes, FSM state encoding
// and key classification helper.
package safe_pkg;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd13;

    localparam logic [2:0] ST_LOCKED   = 3'd0;
    localparam logic [2:0] ST_UNLOCKED = 3'd1;
    localparam logic [2:0] ST_PROGRAM  = 3'd2;
    localparam logic [2:0] ST_LOCKOUT  = 3'd3;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter; expire is high during the cycle the count reads 1.
module safe_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count_r;

    // count register: load has priority, otherwise decrement until zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != '0) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == WIDTH'(1));

endmodule

// File: rtl/safe_lock_controller.sv
// Keypad safe lock: code entry, unlock hold, code programming and lockout after
// repeated bad entries. All outputs are registered from the next-state logic.
module safe_lock_controller
    import safe_pkg::*;
#(
    parameter int                    CODE_LEN       = 4,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    UNLOCK_CYCLES  = 50_000_000,
    parameter int                    LOCKOUT_CYCLES = 500_000_000,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    output logic       unlocked,
    output logic       lockout,
    output logic       err_pulse,
    output logic       prog_ok_pulse,
    output logic [2:0] digit_cnt,
    output logic [2:0] state
);

    localparam int CW   = 4 * CODE_LEN;
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    localparam logic [2:0]    LEN_C      = 3'(CODE_LEN);
    localparam logic [FW-1:0] FAIL_MAX_C = FW'(MAX_FAIL);
    localparam logic [TW-1:0] UNLOCK_C   = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LOCKOUT_C  = TW'(LOCKOUT_CYCLES);

    logic [2:0]    state_r, state_s;
    logic [CW-1:0] entry_r, entry_s;
    logic [2:0]    cnt_r, cnt_s;
    logic [FW-1:0] fail_r, fail_s, fail_inc_s;
    logic [CW-1:0] code_r, code_s;
    logic          unlocked_r, lockout_r, err_r, prog_r;
    logic          err_s, prog_s, load_s, expire_s;
    logic [TW-1:0] load_value_s;
    logic          digit_s, hash_s, star_s, room_s, full_s;

    safe_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .load_value (load_value_s),
        .expire     (expire_s)
    );

    // key classification; codes 12..15 match none of these and fall through
    always_comb begin
        digit_s    = is_digit(key_code);
        hash_s     = (key_code == KEY_HASH);
        star_s     = (key_code == KEY_STAR);
        room_s     = (cnt_r < LEN_C);
        full_s     = (cnt_r == LEN_C);
        fail_inc_s = (fail_r < FAIL_MAX_C) ? (fail_r + FW'(1)) : FAIL_MAX_C;
    end

    // next-state logic; timer expiry is tested first so it wins over a key
    always_comb begin
        state_s      = state_r;
        entry_s      = entry_r;
        cnt_s        = cnt_r;
        fail_s       = fail_r;
        code_s       = code_r;
        err_s        = 1'b0;
        prog_s       = 1'b0;
        load_s       = 1'b0;
        load_value_s = '0;
        case (state_r)
            ST_LOCKED: begin
                if (digit_s && room_s) begin
                    entry_s = {entry_r[CW-5:0], key_code};
                    cnt_s   = cnt_r + 3'd1;
                end else if (star_s) begin
                    entry_s = '0;
                    cnt_s   = 3'd0;
                end else if (hash_s) begin
                    entry_s = '0;
                    cnt_s   = 3'd0;
                    if (full_s && (entry_r == code_r)) begin
                        state_s      = ST_UNLOCKED;
                        fail_s       = '0;
                        load_s       = 1'b1;
                        load_value_s = UNLOCK_C;
                    end else begin
                        err_s  = 1'b1;
                        fail_s = fail_inc_s;
                        if (fail_inc_s == FAIL_MAX_C) begin
                            state_s      = ST_LOCKOUT;
                            load_s       = 1'b1;
                            load_value_s = LOCKOUT_C;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                // returning to LOCKED always parks the timer at zero
                if (expire_s || hash_s) begin
                    state_s = ST_LOCKED;
                    entry_s = '0;
                    cnt_s   = 3'd0;
                    load_s  = 1'b1;
                end else if (star_s) begin
                    state_s = ST_PROGRAM;
                    entry_s = '0;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = ST_UNLOCKED;
                end
            end
            ST_PROGRAM: begin
                if (expire_s) begin
                    state_s = ST_LOCKED;
                    entry_s = '0;
                    cnt_s   = 3'd0;
                    load_s  = 1'b1;
                end else if (digit_s && room_s) begin
                    entry_s = {entry_r[CW-5:0], key_code};
                    cnt_s   = cnt_r + 3'd1;
                end else if (star_s || hash_s) begin
                    state_s = ST_UNLOCKED;
                    entry_s = '0;
                    cnt_s   = 3'd0;
                    if (hash_s && full_s) begin
                        code_s       = entry_r;
                        prog_s       = 1'b1;
                        load_s       = 1'b1;
                        load_value_s = UNLOCK_C;
                    end else begin
                        err_s = hash_s;
                    end
                end else begin
                    state_s = ST_PROGRAM;
                end
            end
            ST_LOCKOUT: begin
                if (expire_s) begin
                    state_s = ST_LOCKED;
                    fail_s  = '0;
                end else begin
                    state_s = ST_LOCKOUT;
                end
            end
            default: begin
                state_s = ST_LOCKED;
                entry_s = '0;
                cnt_s   = 3'd0;
                load_s  = 1'b1;
            end
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_LOCKED;
            entry_r    <= '0;
            cnt_r      <= 3'd0;
            fail_r     <= '0;
            code_r     <= DEFAULT_CODE;
            unlocked_r <= 1'b0;
            lockout_r  <= 1'b0;
            err_r      <= 1'b0;
            prog_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            entry_r    <= entry_s;
            cnt_r      <= cnt_s;
            fail_r     <= fail_s;
            code_r     <= code_s;
            unlocked_r <= (state_s == ST_UNLOCKED) || (state_s == ST_PROGRAM);
            lockout_r  <= (state_s == ST_LOCKOUT);
            err_r      <= err_s;
            prog_r     <= prog_s;
        end
    end

    assign unlocked      = unlocked_r;
    assign lockout       = lockout_r;
    assign err_pulse     = err_r;
    assign prog_ok_pulse = prog_r;
    assign digit_cnt     = cnt_r;
    assign state         = state_r;

endmodule

// File: tb/tb_safe_lock_controller.sv
// Scoreboard bench: a queue-based behavioural model predicts every output cycle,
// a separate monitor pops and compares after each rising edge.
module tb_safe_lock_controller;
    import safe_pkg::*;

    localparam int UNL  = 20;
    localparam int LKO  = 50;
    localparam int MAXF = 3;
    localparam int CLEN = 4;

    localparam int M_LOCKED   = int'(ST_LOCKED);
    localparam int M_UNLOCKED = int'(ST_UNLOCKED);
    localparam int M_PROGRAM  = int'(ST_PROGRAM);
    localparam int M_LOCKOUT  = int'(ST_LOCKOUT);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_code = 4'd13;
    logic       unlocked, lockout, err_pulse, prog_ok_pulse;
    logic [2:0] digit_cnt, state;

    safe_lock_controller #(
        .CODE_LEN       (CLEN),
        .MAX_FAIL       (MAXF),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LKO),
        .DEFAULT_CODE   (16'h1234)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_code      (key_code),
        .unlocked      (unlocked),
        .lockout       (lockout),
        .err_pulse     (err_pulse),
        .prog_ok_pulse (prog_ok_pulse),
        .digit_cnt     (digit_cnt),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       unl;
        logic       lck;
        logic       err;
        logic       prog;
        logic [2:0] dc;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model: entry as a digit queue, code as a packed number,
    // timers as absolute deadlines on a cycle count
    int m_mode;
    int m_entry[$];
    int m_code;
    int m_fails;
    int m_deadline;
    int m_cyc = 0;
    bit m_err, m_prog;
    int seq_q[$];

    function automatic int entry_value();
        int v = 0;
        foreach (m_entry[j]) v = v * 16 + m_entry[j];
        return v;
    endfunction

    task automatic model_reset();
        m_mode     = M_LOCKED;
        m_entry.delete();
        m_code     = 32'h1234;
        m_fails    = 0;
        m_deadline = -1;
        m_err      = 1'b0;
        m_prog     = 1'b0;
    endtask

    task automatic model_step(input int k);
        bit dig = (k <= 9);
        bit hsh = (k == 10);
        bit str = (k == 11);
        bit expired = (m_deadline == m_cyc);
        m_err  = 1'b0;
        m_prog = 1'b0;
        if (m_mode == M_LOCKED) begin
            if (dig) begin
                if (m_entry.size() < CLEN) m_entry.push_back(k);
            end else if (str) begin
                m_entry.delete();
            end else if (hsh) begin
                if (m_entry.size() == CLEN && entry_value() == m_code) begin
                    m_mode = M_UNLOCKED; m_fails = 0; m_deadline = m_cyc + UNL;
                end else begin
                    m_err = 1'b1;
                    if (m_fails < MAXF) m_fails++;
                    if (m_fails == MAXF) begin
                        m_mode = M_LOCKOUT; m_deadline = m_cyc + LKO;
                    end
                end
                m_entry.delete();
            end
        end else if (m_mode == M_UNLOCKED) begin
            if (expired || hsh) begin
                m_mode = M_LOCKED; m_deadline = -1;
            end else if (str) begin
                m_mode = M_PROGRAM;
            end
        end else if (m_mode == M_PROGRAM) begin
            if (expired) begin
                m_mode = M_LOCKED; m_deadline = -1; m_entry.delete();
            end else if (dig) begin
                if (m_entry.size() < CLEN) m_entry.push_back(k);
            end else if (str) begin
                m_mode = M_UNLOCKED; m_entry.delete();
            end else if (hsh) begin
                if (m_entry.size() == CLEN) begin
                    m_code = entry_value(); m_prog = 1'b1; m_deadline = m_cyc + UNL;
                end else begin
                    m_err = 1'b1;
                end
                m_mode = M_UNLOCKED; m_entry.delete();
            end
        end else if (m_mode == M_LOCKOUT) begin
            if (expired) begin
                m_mode = M_LOCKED; m_fails = 0; m_deadline = -1;
            end
        end
    endtask

    // one cycle of stimulus; expectation for the following rising edge is queued
    task automatic drive(input int k, input logic r);
        obs_t e;
        @(negedge clk);
        rst      = r;
        key_code = 4'(k);
        m_cyc++;
        if (!r) model_reset();
        else    model_step(k);
        e.unl  = (m_mode == M_UNLOCKED) || (m_mode == M_PROGRAM);
        e.lck  = (m_mode == M_LOCKOUT);
        e.err  = m_err;
        e.prog = m_prog;
        e.dc   = 3'(m_entry.size());
        e.st   = 3'(m_mode);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(13, 1'b1);
    endtask

    task automatic play_seq();
        foreach (seq_q[i]) drive(seq_q[i], 1'b1);
        seq_q.delete();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(13, 1'b0);
    endtask

    // monitor: compares DUT outputs against the oldest queued expectation
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {unlocked, lockout, err_pulse, prog_ok_pulse, digit_cnt, state};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got unl=%b lck=%b err=%b prog=%b cnt=%0d st=%0d want unl=%b lck=%b err=%b prog=%b cnt=%0d st=%0d",
                             $time, a.unl, a.lck, a.err, a.prog, a.dc, a.st,
                             e.unl, e.lck, e.err, e.prog, e.dc, e.st);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        do_reset(3);
        idle(2);
        // basic unlock and 20-cycle hold
        seq_q = {1, 2, 3, 4, 10}; play_seq();
        idle(25);
        // three bad entries, ignored keys during lockout, recovery
        seq_q = {1, 2, 3, 10, 9, 9, 9, 9, 10, 1, 2, 3, 5, 10, 1, 2, 3, 4, 10}; play_seq();
        idle(55);
        seq_q = {1, 2, 3, 4, 10, 10}; play_seq();
        // star clears entry; fifth digit ignored
        seq_q = {1, 2, 11, 1, 2, 3, 4, 10, 10, 1, 2, 3, 4, 5, 10, 10}; play_seq();
        // key coinciding with expiry: expiry wins
        seq_q = {1, 2, 3, 4, 10}; play_seq();
        idle(19);
        seq_q = {11}; play_seq();
        idle(2);
        // timeout while programming
        seq_q = {1, 2, 3, 4, 10, 11, 7}; play_seq();
        idle(22);
        // program new code, old code rejected, new code accepted
        seq_q = {1, 2, 3, 4, 10, 11, 5, 6, 7, 8, 10, 10, 1, 2, 3, 4, 10, 5, 6, 7, 8, 10, 10}; play_seq();
        // short program entry, then reset mid-program restores default
        seq_q = {5, 6, 7, 8, 10, 11, 5, 10, 11, 1, 2}; play_seq();
        do_reset(2);
        seq_q = {5, 6, 7, 8, 10, 1, 2, 3, 4, 10, 12, 14, 15, 10}; play_seq();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 40) begin
                for (int j = CLEN - 1; j >= 0; j--) seq_q.push_back((m_code >> (4 * j)) & 15);
                seq_q.push_back(10);
                play_seq();
            end else if (r < 43) begin
                do_reset(1);
            end else if (r < 550) begin
                drive(int'($urandom_range(0, 9)), 1'b1);
            end else if (r < 650) begin
                drive(10, 1'b1);
            end else if (r < 720) begin
                drive(11, 1'b1);
            end else if (r < 800) begin
                drive(int'($urandom_range(12, 15)), 1'b1);
            end else begin
                drive(13, 1'b1);
            end
        end
        idle(3);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/safe_lock_controller.md
SAFE_LOCK_CONTROLLER -- requirements
Module: safe_lock_controller

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  CODE_LEN, 4, digits per code
  MAX_FAIL, 3, consecutive bad entries before lockout
  UNLOCK_CYCLES, 50_000_000, unlocked/program hold time in clk cycles
  LOCKOUT_CYCLES, 500_000_000, lockout duration in clk cycles
  DEFAULT_CODE, 16'h1234, code after reset, 4-bit BCD per digit, MSB digit first
REQ-002 SHALL have ports, one per line (name direction width meaning):
  clk  input  1  clock
  rst  input  1  reset, asynchronous, active-low
  key_code  input  4  keypad code: 0-9 digit, 10 hash/enter, 11 star, 13 none; each press is one cycle
  unlocked  output  1  bolt release, level
  lockout  output  1  lockout active, level
  err_pulse  output  1  one-cycle pulse on rejected entry
  prog_ok_pulse  output  1  one-cycle pulse on new code stored
  digit_cnt  output  3  digits buffered in current entry, 0..CODE_LEN
  state  output  3  FSM state encoding, for debug

Function
REQ-003 SHALL implement states LOCKED, UNLOCKED, PROGRAM, LOCKOUT.
REQ-004 SHALL ignore key_code values 12, 13, 14, 15 in every state.
REQ-005 SHALL, in LOCKED or PROGRAM, on a digit with digit_cnt < CODE_LEN, shift it into the entry buffer (buf <= {buf[11:0], digit}) and increment digit_cnt; SHALL ignore digits once digit_cnt == CODE_LEN.
REQ-006 SHALL, in LOCKED on star, clear the buffer and set digit_cnt to 0, with no error.
REQ-007 SHALL, in LOCKED on hash: if digit_cnt == CODE_LEN and buf == stored code, go to UNLOCKED, clear fail count, load the timer with UNLOCK_CYCLES; otherwise pulse err_pulse, increment fail count, and stay in LOCKED.
REQ-008 SHALL go to LOCKOUT, with the timer loaded to LOCKOUT_CYCLES, on the failed hash that makes fail count equal MAX_FAIL; err_pulse SHALL also pulse on that cycle.
REQ-009 SHALL register all outputs; unlocked/lockout/err_pulse SHALL change on the clock edge after the hash cycle (1-cycle latency).
REQ-010 SHALL clear buf and digit_cnt on every state transition and on every hash.
REQ-011 UNLOCKED: unlocked=1; digits ignored; hash goes to LOCKED immediately; star goes to PROGRAM; timer reaching 0 goes to LOCKED.
REQ-012 PROGRAM: unlocked=1; timer keeps counting; hash with digit_cnt == CODE_LEN writes buf to the stored code, pulses prog_ok_pulse, goes to UNLOCKED, and reloads UNLOCK_CYCLES; hash with digit_cnt < CODE_LEN pulses err_pulse and goes to UNLOCKED with the code unchanged; star aborts to UNLOCKED with the code unchanged; timeout goes to LOCKED with the code unchanged.
REQ-013 PROGRAM errors SHALL NOT change fail count.
REQ-014 LOCKOUT: lockout=1; all keys ignored; timer reaching 0 goes to LOCKED and clears fail count.
REQ-015 The timer SHALL be a down-counter of width $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1) that decrements once per cycle; expiry is the cycle in which it reads 1.
REQ-016 If a key and timer expiry coincide, expiry SHALL win and the key SHALL be discarded.
REQ-017 fail count SHALL saturate at MAX_FAIL.

Reset
REQ-018 While rst=0, SHALL force: state LOCKED, unlocked=0, lockout=0, err_pulse=0, prog_ok_pulse=0, digit_cnt=0, buf=0, fail count 0, timer 0, stored code DEFAULT_CODE.
REQ-019 Reset mid-operation SHALL discard any programmed code and revert to DEFAULT_CODE.

Structure
REQ-020 Shared package safe_pkg SHALL hold the key constants (KEY_HASH=10, KEY_STAR=11, KEY_NONE=13) and the state encoding.
REQ-021 Timer SHALL be a sub-module safe_timer (load, load_value, expire); the remaining logic SHALL be flat.

Verification (bench params: UNLOCK_CYCLES=20, LOCKOUT_CYCLES=50, MAX_FAIL=3)
REQ-022 Keys 1,2,3,4,hash -> unlocked=1 one cycle after hash; held 20 cycles; then unlocked=0.
REQ-023 Keys 1,2,3,hash, then 9,9,9,9,hash, then 1,2,3,5,hash -> err_pulse on each hash; lockout=1 after the third; keys 1,2,3,4,hash during lockout are ignored; lockout=0 after 50 cycles; then 1,2,3,4,hash unlocks.
REQ-024 Unlock, then star,5,6,7,8,hash -> prog_ok_pulse; hash relocks; 1,2,3,4,hash -> err_pulse; 5,6,7,8,hash -> unlocked.
REQ-025 Keys 1,2,star,1,2,3,4,hash -> unlocked; keys 1,2,3,4,5,hash -> unlocked (5th digit ignored).
REQ-026 Unlock, star,5,hash -> err_pulse, code unchanged; assert rst mid-PROGRAM -> all outputs 0 and DEFAULT_CODE restored.
